// File: rtl/debug_seg7_display.sv
// Eight-digit multiplexed seven-segment debug display with per-frame snapshot and register-index stepping.
// Optional leading-zero blanking when SEG_LZ_BLANK_EN is defined; an/seg are registered (1 clock behind d/snap).
module debug_seg7_display #(
   parameter int SCAN_DIV = 50000,
   parameter int STEP_DIV = 50000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  sel_mode,
   input  logic        freeze,
   input  logic        auto_reg,
   input  logic [4:0]  reg_sel_sw,
   input  logic [31:0] pc_in,
   input  logic [31:0] instr_in,
   input  logic [31:0] reg_data_in,
   input  logic [31:0] mem_addr_in,
   input  logic [31:0] mem_data_in,
   input  logic [31:0] debug_in,
   input  logic        stall_in,
   output logic [4:0]  reg_sel_out,
   output logic [7:0]  an,
   output logic [7:0]  seg
);

   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

   logic [SCAN_W-1:0] scan_cnt;
   logic [STEP_W-1:0] step_cnt;
   logic [2:0]        d;
   logic [31:0]       snap;
   logic              snap_stall;
   logic              primed;
   logic [31:0]       src;
   logic [3:0]        nibble;
   logic [6:0]        seg_dec;
   logic              blank;

   always_comb begin
      src = 32'd0;
      case (sel_mode)
         3'd0:    src = pc_in;
         3'd1:    src = instr_in;
         3'd2:    src = reg_data_in;
         3'd3:    src = mem_addr_in;
         3'd4:    src = mem_data_in;
         3'd5:    src = debug_in;
         default: src = 32'd0;
      endcase
   end

   always_comb begin
      nibble  = snap[{d, 2'b00} +: 4];
      seg_dec = 7'h7F;
      case (nibble)
         4'h0: seg_dec = 7'h40;
         4'h1: seg_dec = 7'h79;
         4'h2: seg_dec = 7'h24;
         4'h3: seg_dec = 7'h30;
         4'h4: seg_dec = 7'h19;
         4'h5: seg_dec = 7'h12;
         4'h6: seg_dec = 7'h02;
         4'h7: seg_dec = 7'h78;
         4'h8: seg_dec = 7'h00;
         4'h9: seg_dec = 7'h10;
         4'hA: seg_dec = 7'h08;
         4'hB: seg_dec = 7'h03;
         4'hC: seg_dec = 7'h46;
         4'hD: seg_dec = 7'h21;
         4'hE: seg_dec = 7'h06;
         4'hF: seg_dec = 7'h0E;
         default: seg_dec = 7'h7F;
      endcase
   end

`ifdef SEG_LZ_BLANK_EN
   // A digit is blank when it and every digit to its left are zero.
   assign blank = (d != 3'd0) && ((snap >> {d, 2'b00}) == 32'd0);
`else
   assign blank = 1'b0;
`endif

   // The first clock after reset only loads the snapshot; scanning starts on the next one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         primed     <= 1'b0;
         scan_cnt   <= '0;
         d          <= 3'd0;
         snap       <= 32'd0;
         snap_stall <= 1'b0;
         an         <= 8'hFF;
         seg        <= 8'hFF;
      end else begin
         primed <= 1'b1;
         if (!primed) begin
            snap       <= src;
            snap_stall <= stall_in;
         end else begin
            if (scan_cnt == SCAN_LAST) begin
               scan_cnt <= '0;
               d        <= d + 3'd1;
               if (d == 3'd7 && !freeze) begin
                  snap       <= src;
                  snap_stall <= stall_in;
               end
            end else begin
               scan_cnt <= scan_cnt + 1'b1;
            end
            if (blank) begin
               an  <= 8'hFF;
               seg <= 8'hFF;
            end else begin
               an  <= ~(8'd1 << d);
               seg <= {~((d == 3'd0) && snap_stall), seg_dec};
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_cnt    <= '0;
         reg_sel_out <= 5'd0;
      end else if (!auto_reg) begin
         step_cnt    <= '0;
         reg_sel_out <= reg_sel_sw;
      end else if (step_cnt == STEP_LAST) begin
         step_cnt    <= '0;
         reg_sel_out <= reg_sel_out + 5'd1;
      end else begin
         step_cnt <= step_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_debug_seg7_display.sv
// Randomized bench for debug_seg7_display against a cycle-count based reference model.
module tb_debug_seg7_display;

   localparam int SCAN = 4;
   localparam int STEP = 8;
   localparam int FRAME = 8 * SCAN;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  sel_mode;
   logic        freeze;
   logic        auto_reg;
   logic [4:0]  reg_sel_sw;
   logic [31:0] pc_in, instr_in, reg_data_in, mem_addr_in, mem_data_in, debug_in;
   logic        stall_in;
   logic [4:0]  reg_sel_out;
   logic [7:0]  an;
   logic [7:0]  seg;

   logic [31:0] rf [32];
   logic [6:0]  seg_tab [16];

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   int          k;
   int          stp;
   logic [31:0] snap_m;
   logic        stall_m;
   logic [7:0]  exp_an;
   logic [7:0]  exp_seg;
   logic [4:0]  exp_reg;

   always #5 clk = ~clk;

   // Register file stand-in for the SoC: read port follows reg_sel_out combinationally.
   assign reg_data_in = rf[reg_sel_out];

   debug_seg7_display #(.SCAN_DIV(SCAN), .STEP_DIV(STEP)) dut (
      .clk(clk), .rst(rst), .sel_mode(sel_mode), .freeze(freeze), .auto_reg(auto_reg),
      .reg_sel_sw(reg_sel_sw), .pc_in(pc_in), .instr_in(instr_in), .reg_data_in(reg_data_in),
      .mem_addr_in(mem_addr_in), .mem_data_in(mem_data_in), .debug_in(debug_in),
      .stall_in(stall_in), .reg_sel_out(reg_sel_out), .an(an), .seg(seg)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] src_val();
      case (sel_mode)
         3'd0: return pc_in;
         3'd1: return instr_in;
         3'd2: return reg_data_in;
         3'd3: return mem_addr_in;
         3'd4: return mem_data_in;
         3'd5: return debug_in;
         default: return 32'd0;
      endcase
   endfunction

   // Model: k = edges since reset release; the output after edge k>=2 shows
   // digit ((k-2)/SCAN)%8 of the snapshot held before that edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         k = 0; stp = 0; snap_m = 0; stall_m = 0;
         exp_an = 8'hFF; exp_seg = 8'hFF; exp_reg = 5'd0;
      end else begin
         int c, dig;
         logic blank;
         k++;
         if (k == 1) begin
            exp_an = 8'hFF; exp_seg = 8'hFF;
            snap_m = src_val(); stall_m = stall_in;
         end else begin
            c   = k - 2;
            dig = (c / SCAN) % 8;
            blank = 1'b0;
`ifdef SEG_LZ_BLANK_EN
            blank = (dig > 0) && ((snap_m >> (4 * dig)) == 0);
`endif
            if (blank) begin
               exp_an = 8'hFF; exp_seg = 8'hFF;
            end else begin
               exp_an  = 8'hFF;
               exp_an[dig] = 1'b0;
               exp_seg = {!(dig == 0 && stall_m), seg_tab[(snap_m >> (4 * dig)) & 32'hF]};
            end
            if ((c % FRAME) == FRAME - 1 && !freeze) begin
               snap_m = src_val(); stall_m = stall_in;
            end
         end
         if (!auto_reg) begin
            stp = 0; exp_reg = reg_sel_sw;
         end else begin
            stp++;
            if (stp == STEP) begin
               stp = 0; exp_reg = exp_reg + 5'd1;
            end
         end
      end
   end

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("an", {24'd0, an}, {24'd0, exp_an});
         chk("seg", {24'd0, seg}, {24'd0, exp_seg});
         chk("reg_sel", {27'd0, reg_sel_out}, {27'd0, exp_reg});
      end
   endtask

   initial begin
      bit found;
      seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      rst = 1'b1; sel_mode = 3'd0; freeze = 1'b0; auto_reg = 1'b0; reg_sel_sw = 5'd0;
      pc_in = 32'h0000_1234; instr_in = 32'h1111_2222; mem_addr_in = 32'h0;
      mem_data_in = 32'h0; debug_in = 32'h0; stall_in = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_an", {24'd0, an}, 32'hFF);
      chk("rst_seg", {24'd0, seg}, 32'hFF);
      chk("rst_reg", {27'd0, reg_sel_out}, 32'd0);
      rst = 1'b0;

      // First frames with a fixed PC, then a mid-frame change.
      cyc(FRAME + 10);
      pc_in = 32'hDEAD_BEEF;
      cyc(2 * FRAME);

      // Frozen snapshot while instr toggles.
      sel_mode = 3'd1; freeze = 1'b1;
      for (int i = 0; i < 3 * FRAME; i++) begin
         instr_in = ~instr_in;
         cyc(1);
      end
      freeze = 1'b0;

      // Stall dp, plus auto-step from 30 through the wrap, then back to switches.
      stall_in = 1'b1; reg_sel_sw = 5'd30;
      cyc(2);
      auto_reg = 1'b1;
      cyc(FRAME + 5);
      auto_reg = 1'b0; reg_sel_sw = 5'd5; stall_in = 1'b0;
      cyc(3);

      // Randomized operation.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 3) sel_mode = 3'($urandom);
         if ($urandom_range(0, 99) < 2) freeze = ~freeze;
         if ($urandom_range(0, 99) < 5) stall_in = ~stall_in;
         if ($urandom_range(0, 199) < 1) auto_reg = ~auto_reg;
         if ($urandom_range(0, 99) < 10) reg_sel_sw = 5'($urandom);
         pc_in       = $urandom >> $urandom_range(0, 31);
         instr_in    = $urandom;
         mem_addr_in = $urandom >> $urandom_range(0, 31);
         mem_data_in = $urandom;
         debug_in    = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 99) < 10) rf[$urandom_range(0, 31)] = $urandom >> $urandom_range(0, 31);
         cyc(1);
      end

      // Mid-frame asynchronous reset while digit 2 is lit.
      freeze = 1'b0; sel_mode = 3'd0; pc_in = 32'h0000_00A0; stall_in = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 4 * FRAME && !found; i++) begin
         cyc(1);
         if (an == 8'hFB) found = 1'b1;
      end
      if (!found) chk("wait_an_fb", {24'd0, an}, 32'hFB);
      #2 rst = 1'b1;
      #1;
      chk("async_an", {24'd0, an}, 32'hFF);
      chk("async_seg", {24'd0, seg}, 32'hFF);
      chk("async_reg", {27'd0, reg_sel_out}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      cyc(3 * FRAME);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
